// File: rtl/ulam_pkg.sv
// Shared types, default sizes and the Ulam step function for the ulam datapath.
package ulam_pkg;

  localparam int ULAM_WIDTH    = 16;
  localparam int ULAM_STEP_W   = 10;
  localparam int ULAM_WD_LIMIT = 1000;
  localparam int MAX_W         = 32;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE,
    ALERT
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] nxt;
  } step_t;

  // 3n+1 is formed two bits wider than MAX_W so it cannot wrap;
  // ovf flags any result that does not fit in w bits.
  function automatic step_t ulam_next(
    input logic [MAX_W-1:0] n,
    input int unsigned      w
  );
    logic [MAX_W+1:0] t;
    step_t r;
    if (n[0])
      t = ({2'b00, n} << 1) + {2'b00, n} + (MAX_W+2)'(1);
    else
      t = {3'b000, n[MAX_W-1:1]};
    r.nxt = t[MAX_W-1:0];
    r.ovf = (t >> w) != '0;
    return r;
  endfunction

endpackage

// File: rtl/ulam_step.sv
// Combinational Ulam step: next value, overflow and reached-one flags.
module ulam_step
  import ulam_pkg::*;
#(
  parameter int WIDTH = ULAM_WIDTH
) (
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] next,
  output logic             ovf,
  output logic             is_one
);

  step_t s;

  assign s      = ulam_next(MAX_W'(n), WIDTH);
  assign next   = s.nxt[WIDTH-1:0];
  assign ovf    = s.ovf;
  assign is_one = (next == WIDTH'(1));

  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^s.nxt[MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/ulam_core.sv
// Ulam sequence datapath: FSM, value/step registers and watchdog.
// Optional peak tracking output when ULAM_PEAK_EN is defined.
module ulam_core
  import ulam_pkg::*;
#(
  parameter int WIDTH          = ULAM_WIDTH,
  parameter int STEP_W         = ULAM_STEP_W,
  parameter int WATCHDOG_LIMIT = ULAM_WD_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              go,
  input  logic              run,
  input  logic [WIDTH-1:0]  seed,
  output logic [WIDTH-1:0]  value,
  output logic [STEP_W-1:0] steps,
  output logic              done,
  output logic              alert,
  output logic              busy
`ifdef ULAM_PEAK_EN
  ,
  output logic [WIDTH-1:0]  peak
`endif
);

  state_t            state, state_d;
  logic [WIDTH-1:0]  value_d;
  logic [STEP_W-1:0] steps_d, steps_inc;
  logic              done_d, alert_d;
  logic [WIDTH-1:0]  next;
  logic              ovf, is_one;

  ulam_step #(.WIDTH(WIDTH)) u_step (
    .n      (value),
    .next   (next),
    .ovf    (ovf),
    .is_one (is_one)
  );

  assign steps_inc = steps + STEP_W'(1);
  assign busy      = (state == ITER);

`ifdef ULAM_PEAK_EN
  logic [WIDTH-1:0] peak_d;
`endif

  always_comb begin
    state_d = state;
    value_d = value;
    steps_d = steps;
    done_d  = done;
    alert_d = alert;
`ifdef ULAM_PEAK_EN
    peak_d  = peak;
`endif
    if (clear) begin
      state_d = IDLE;
      value_d = '0;
      steps_d = '0;
      done_d  = 1'b0;
      alert_d = 1'b0;
`ifdef ULAM_PEAK_EN
      peak_d  = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (go && enable) begin
            value_d = seed;
            steps_d = '0;
`ifdef ULAM_PEAK_EN
            peak_d  = seed;
`endif
            unique case (1'b1)
              (seed == '0): begin
                alert_d = 1'b1;
                state_d = ALERT;
              end
              (seed == WIDTH'(1)): begin
                done_d  = 1'b1;
                state_d = DONE;
              end
              default: state_d = ITER;
            endcase
          end
        end
        ITER: begin
          if (run) begin
            if (ovf) begin
              alert_d = 1'b1;
              state_d = ALERT;
            end else begin
              value_d = next;
              steps_d = steps_inc;
`ifdef ULAM_PEAK_EN
              if (next > peak) peak_d = next;
`endif
              // Reaching one on the limit step wins over the watchdog.
              unique case (1'b1)
                is_one: begin
                  done_d  = 1'b1;
                  state_d = DONE;
                end
                (steps_inc == STEP_W'(WATCHDOG_LIMIT)): begin
                  alert_d = 1'b1;
                  state_d = ALERT;
                end
                default: ;
              endcase
            end
          end
        end
        DONE:  ;
        ALERT: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      value <= '0;
      steps <= '0;
      done  <= 1'b0;
      alert <= 1'b0;
`ifdef ULAM_PEAK_EN
      peak  <= '0;
`endif
    end else begin
      state <= state_d;
      value <= value_d;
      steps <= steps_d;
      done  <= done_d;
      alert <= alert_d;
`ifdef ULAM_PEAK_EN
      peak  <= peak_d;
`endif
    end
  end

endmodule

// File: tb/tb_ulam_core.sv
// Scoreboard bench for ulam_core; a second instance runs a short watchdog.
module tb_ulam_core;

  logic        clock = 1'b0;
  logic        reset, clear, enable, go, run;
  logic [15:0] seed;
  logic [15:0] value, wd_value;
  logic [9:0]  steps, wd_steps;
  logic        done, alert, busy;
  logic        wd_done, wd_alert, wd_busy;
`ifdef ULAM_PEAK_EN
  logic [15:0] peak, wd_peak;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] v;
    logic [9:0]  s;
    logic        d;
    logic        a;
    logic        b;
    logic [15:0] p;
  } exp_t;

  exp_t q[$];

  longint m_v, m_s, m_p;
  int     m_st;
  logic   m_d, m_a;

  always #5 clock = ~clock;

  ulam_core u_dut (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .go     (go),
    .run    (run),
    .seed   (seed),
    .value  (value),
    .steps  (steps),
    .done   (done),
    .alert  (alert),
    .busy   (busy)
`ifdef ULAM_PEAK_EN
    ,
    .peak   (peak)
`endif
  );

  ulam_core #(.WATCHDOG_LIMIT(100)) u_wd (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .go     (go),
    .run    (run),
    .seed   (seed),
    .value  (wd_value),
    .steps  (wd_steps),
    .done   (wd_done),
    .alert  (wd_alert),
    .busy   (wd_busy)
`ifdef ULAM_PEAK_EN
    ,
    .peak   (wd_peak)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint nx;
    if (clear) begin
      m_v = 0; m_s = 0; m_p = 0; m_d = 0; m_a = 0; m_st = 0;
    end else if (m_st == 0) begin
      if (go && enable) begin
        m_v = seed; m_s = 0; m_p = seed;
        if (seed == 0) begin m_a = 1; m_st = 3; end
        else if (seed == 1) begin m_d = 1; m_st = 2; end
        else m_st = 1;
      end
    end else if (m_st == 1 && run) begin
      nx = (m_v % 2 == 1) ? 3 * m_v + 1 : m_v / 2;
      if (nx > 65535) begin
        m_a = 1; m_st = 3;
      end else begin
        m_v = nx; m_s = m_s + 1;
        if (nx > m_p) m_p = nx;
        if (nx == 1) begin m_d = 1; m_st = 2; end
        else if (m_s == 1000) begin m_a = 1; m_st = 3; end
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_edge();
    e.v = 16'(m_v); e.s = 10'(m_s); e.d = m_d; e.a = m_a;
    e.b = (m_st == 1); e.p = 16'(m_p);
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("value", 32'(value), 32'(e.v));
    chk("steps", 32'(steps), 32'(e.s));
    chk("done", 32'(done), 32'(e.d));
    chk("alert", 32'(alert), 32'(e.a));
    chk("busy", 32'(busy), 32'(e.b));
`ifdef ULAM_PEAK_EN
    chk("peak", 32'(peak), 32'(e.p));
`endif
  endtask

  task automatic do_clear();
    clear = 1; cyc(); clear = 0;
  endtask

  task automatic load(input logic [15:0] sd);
    seed = sd; go = 1; enable = 1; cyc(); go = 0; enable = 0;
  endtask

  task automatic run_n(input int n);
    run = 1;
    for (int i = 0; i < n; i++) cyc();
    run = 0;
  endtask

  initial begin
    reset = 1; clear = 0; enable = 0; go = 0; run = 0; seed = '0;
    m_v = 0; m_s = 0; m_p = 0; m_d = 0; m_a = 0; m_st = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_value", 32'(value), 0);
    chk("rst_steps", 32'(steps), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_alert", 32'(alert), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 0;

    seed = 16'd6; go = 1; enable = 0; cyc(); go = 0;
    chk("go_noen_busy", 32'(busy), 0);

    load(16'd6);
    run_n(7);
    chk("s6_pre_done", 32'(done), 0);
    run_n(3);
    chk("s6_steps", 32'(steps), 8);
    chk("s6_done", 32'(done), 1);
`ifdef ULAM_PEAK_EN
    chk("s6_peak", 32'(peak), 16);
`endif

    do_clear();
    load(16'd27);
    run_n(115);
    chk("s27_steps", 32'(steps), 111);
    chk("s27_alert", 32'(alert), 0);
`ifdef ULAM_PEAK_EN
    chk("s27_peak", 32'(peak), 9232);
`endif

    do_clear();
    load(16'd1);
    chk("s1_done", 32'(done), 1);
    run_n(3);
    chk("s1_busy", 32'(busy), 0);

    do_clear();
    load(16'd0);
    chk("s0_alert", 32'(alert), 1);
    chk("s0_done", 32'(done), 0);

    do_clear();
    load(16'hFFFF);
    run_n(2);
    chk("ovf_value", 32'(value), 65535);
    chk("ovf_steps", 32'(steps), 0);
    chk("ovf_alert", 32'(alert), 1);

    do_clear();
    load(16'd27);
    run_n(50);
    do_clear();
    chk("clr_value", 32'(value), 0);
    chk("clr_busy", 32'(busy), 0);
    load(16'd6);
    run_n(3);
    cyc(); cyc();
    chk("hold_steps", 32'(steps), 3);
    run_n(6);
    chk("resume_done", 32'(done), 1);

    do_clear();
    load(16'd27);
    run_n(99);
    chk("wd_pre_alert", 32'(wd_alert), 0);
    run_n(1);
    chk("wd_alert", 32'(wd_alert), 1);
    chk("wd_steps", 32'(wd_steps), 100);
    chk("wd_done", 32'(wd_done), 0);
    chk("wd_busy", 32'(wd_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulam_core.md
Name: ulam_core

Overview:
- Datapath stage directly downstream of the ulam control block. Consumes its clear/run/go/enable strobes and produces the done and alert signals that the controller watches.
- Iterates the Ulam (Collatz) map on a loaded seed, one step per clock: n even -> n/2, n odd -> 3n+1. Stops when the value reaches 1.
- Counts steps and raises alert on arithmetic overflow or watchdog expiry, so a runaway sequence cannot hang the controller.

Parameters:
- WIDTH, 16, bit width of seed and value register.
- STEP_W, 10, bit width of step counter.
- WATCHDOG_LIMIT, 1000, step count at which a still-running sequence is aborted. Must fit in STEP_W bits.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear from controller; returns to IDLE.
- enable  input  1  qualifies seed load.
- go  input  1  load strobe; seed captured when go & enable in IDLE.
- run  input  1  step enable; one iteration per cycle while high in ITER.
- seed  input  WIDTH  starting value.
- value  output  WIDTH  current sequence value.
- steps  output  STEP_W  iterations performed since load.
- done  output  1  sticky; sequence reached 1.
- alert  output  1  sticky; overflow, zero seed or watchdog expiry.
- busy  output  1  high in ITER.

Behaviour:
- Reset values: value=0, steps=0, done=0, alert=0, busy=0, state=IDLE.
- Priority per edge: reset > clear > load/step. Clear has the same effect as reset; it aborts mid-run with no residual output.
- States: IDLE, ITER, DONE, ALERT.
- IDLE: on go & enable, value<=seed and steps<=0. Then:
  - seed==0: alert<=1 on the same edge, go to ALERT.
  - seed==1: done<=1 on the same edge, go to DONE.
  - otherwise: go to ITER.
  - go without enable is ignored.
- ITER: on each edge with run=1, value<=next and steps<=steps+1. run=0 holds all state; busy stays 1.
- The edge that writes next==1 also sets done=1 and moves to DONE. Latency is therefore N run-cycles for an N-step sequence.
- Arithmetic: 3n+1 computed at WIDTH+2 bits. If the result exceeds 2^WIDTH-1, the step is not committed (value and steps hold), alert<=1, and the state moves to ALERT.
- Watchdog: if steps+1 == WATCHDOG_LIMIT and next != 1, the step is committed, alert<=1, and the state moves to ALERT. Reaching 1 exactly on the limit step counts as done, not alert.
- DONE/ALERT: all outputs hold; go and run are ignored. Only clear or reset leave these states.
- done and alert are never high together.
- steps never wraps; the watchdog fires first because LIMIT < 2^STEP_W.

Optional Feature:
- Macro ULAM_PEAK_EN.
- Defined: adds output peak [WIDTH]. Reset/clear to 0; loaded with seed on load; updated to max(peak, next) on each committed step.
- Undefined: peak port is absent and no peak logic is built. All other behaviour is identical.

Decomposition:
- Package ulam_pkg holds:
  - state enum (IDLE, ITER, DONE, ALERT);
  - default WIDTH/STEP_W/WATCHDOG_LIMIT constants;
  - a function computing the next value plus an overflow flag.
- One sub-module is natural: ulam_step, purely combinational. Takes n [WIDTH]; outputs next [WIDTH], ovf and is_one.
- ulam_core holds the FSM, registers and watchdog.

Test Plan:
- seed=6, go&enable, run held high -> value sequence 3,10,5,16,8,4,2,1; done rises on 8th run edge; steps=8; peak=16 with ULAM_PEAK_EN.
- seed=27, run high -> done after 111 edges, steps=111, alert=0; peak=9232 with ULAM_PEAK_EN.
- seed=1 -> done=1 on load edge, steps=0, busy never high. seed=0 -> alert=1 on load edge, done=0.
- seed=65535 (WIDTH=16) -> first step overflows; alert=1, value stays 65535, steps=0.
- WATCHDOG_LIMIT=100, seed=27 -> alert=1 on 100th run edge, steps=100, done=0.
- seed=27, clear at step 50 -> next cycle value=0, steps=0, busy=0. Reload seed=6 -> done after 8 steps. run toggled low mid-sequence -> values freeze and resume unchanged.
